// File: rtl/turn_signal_ctrl.sv
// Driver-input front end for the tail-light sequencer: syncs and debounces the stalk and hazard
// inputs, divides the system clock to Clk_2Hz, latches hazard and runs the turn/tap FSM.
module turn_signal_ctrl #(
  parameter int unsigned DEB_CYCLES  = 500000,
  parameter int unsigned HALF_DIV    = 12500000,
  parameter int unsigned TAP_TICKS   = 2,
  parameter int unsigned TAP_FLASHES = 12
) (
  input  logic Clk,
  input  logic RST,
  input  logic SW_LEFT,
  input  logic SW_RIGHT,
  input  logic BTN_HAZ,
  output logic Clk_2Hz,
  output logic LEFT,
  output logic RIGHT,
  output logic HAZ
);

  localparam int unsigned DebW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned DivW = $clog2(HALF_DIV + 1);
  localparam logic [DebW-1:0] DebMax = DebW'(DEB_CYCLES - 1);
  localparam logic [DivW-1:0] DivMax = DivW'(HALF_DIV - 1);
  localparam logic [4:0] TapTicks = 5'(TAP_TICKS);
  localparam logic [4:0] TapFlashes = 5'(TAP_FLASHES);

  typedef enum logic [2:0] {
    StIdle,
    StLeftOn,
    StLeftTap,
    StRightOn,
    StRightTap
  } state_t;

  // Bit 0 = left stalk, bit 1 = right stalk, bit 2 = hazard button.
  logic [2:0]      raw;
  logic [2:0]      sync1_q, sync2_q, deb_q;
  logic [DebW-1:0] deb_cnt_q [3];

  assign raw = {BTN_HAZ, SW_RIGHT, SW_LEFT};

  always_ff @(posedge Clk) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DebMax) begin
          deb_q[i]     <= sync2_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic [DivW-1:0] div_cnt_q;
  logic            tick_q;

  // tick_q is high for the one cycle in which Clk_2Hz has just become 1.
  always_ff @(posedge Clk) begin
    if (RST) begin
      div_cnt_q <= '0;
      Clk_2Hz   <= 1'b0;
      tick_q    <= 1'b0;
    end else if (div_cnt_q == DivMax) begin
      div_cnt_q <= '0;
      Clk_2Hz   <= ~Clk_2Hz;
      tick_q    <= ~Clk_2Hz;
    end else begin
      div_cnt_q <= div_cnt_q + 1'b1;
      tick_q    <= 1'b0;
    end
  end

  logic haz_prev_q;

  always_ff @(posedge Clk) begin
    if (RST) begin
      haz_prev_q <= 1'b0;
      HAZ        <= 1'b0;
    end else begin
      haz_prev_q <= deb_q[2];
      if (deb_q[2] && !haz_prev_q) HAZ <= ~HAZ;
    end
  end

  state_t     state_q, state_d;
  logic [4:0] edge_cnt_q, edge_cnt_d, cnt_inc;
  logic       l, r, keep_cnt;

  assign l = deb_q[0];
  assign r = deb_q[1];

  always_comb begin
    cnt_inc  = (tick_q && edge_cnt_q != 5'd31) ? edge_cnt_q + 5'd1 : edge_cnt_q;
    state_d  = state_q;
    keep_cnt = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (l && !r)      state_d = StLeftOn;
        else if (r && !l) state_d = StRightOn;
      end
      StLeftOn: begin
        if (l && r) begin
          state_d = StIdle;
        end else if (!l) begin
          keep_cnt = (cnt_inc < TapTicks);
          state_d  = keep_cnt ? StLeftTap : StIdle;
        end
      end
      StRightOn: begin
        if (l && r) begin
          state_d = StIdle;
        end else if (!r) begin
          keep_cnt = (cnt_inc < TapTicks);
          state_d  = keep_cnt ? StRightTap : StIdle;
        end
      end
      StLeftTap, StRightTap: begin
        // Fault is checked first so it wins over a simultaneous expiry.
        if (l && r)                     state_d = StIdle;
        else if (r)                     state_d = StRightOn;
        else if (l)                     state_d = StLeftOn;
        else if (cnt_inc >= TapFlashes) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    edge_cnt_d = (state_d != state_q && !keep_cnt) ? 5'd0 : cnt_inc;
  end

  always_ff @(posedge Clk) begin
    if (RST) begin
      state_q    <= StIdle;
      edge_cnt_q <= '0;
      LEFT       <= 1'b0;
      RIGHT      <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      LEFT       <= (state_d == StLeftOn) || (state_d == StLeftTap);
      RIGHT      <= (state_d == StRightOn) || (state_d == StRightTap);
    end
  end

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Scoreboard bench for turn_signal_ctrl: directed scenarios plus random stalk/button activity,
// checked every cycle against a timeline-based reference model.
module tb_turn_signal_ctrl;

  localparam int DEB = 4;
  localparam int HD  = 5;
  localparam int TT  = 2;
  localparam int TF  = 12;

  logic Clk = 1'b0;
  logic RST = 1'b1;
  logic SW_LEFT = 1'b0, SW_RIGHT = 1'b0, BTN_HAZ = 1'b0;
  logic Clk_2Hz, LEFT, RIGHT, HAZ;

  turn_signal_ctrl #(
    .DEB_CYCLES (DEB),
    .HALF_DIV   (HD),
    .TAP_TICKS  (TT),
    .TAP_FLASHES(TF)
  ) dut (
    .Clk     (Clk),
    .RST     (RST),
    .SW_LEFT (SW_LEFT),
    .SW_RIGHT(SW_RIGHT),
    .BTN_HAZ (BTN_HAZ),
    .Clk_2Hz (Clk_2Hz),
    .LEFT    (LEFT),
    .RIGHT   (RIGHT),
    .HAZ     (HAZ)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [3:0] expq[$];

  // Reference model state: edges since reset release, input pipeline, stable levels,
  // and the active turn side (0 none, 1 left, 2 right) with tap flag and tick count.
  int   k;
  bit   m_s1[3], m_s2[3], m_deb[3];
  int   m_streak[3];
  bit   m_hprev, m_haz;
  int   m_side, m_cnt;
  bit   m_tap;
  bit   cur_l, cur_r, cur_h;

  function automatic bit div_level(int e);
    return (e > 0) && (((e / HD) % 2) == 1);
  endfunction

  function automatic bit rose_at(int e);
    return (e >= 1) && (e % HD == 0) && (((e / HD) % 2) == 1);
  endfunction

  task automatic model_reset();
    k = 0; m_hprev = 0; m_haz = 0; m_side = 0; m_cnt = 0; m_tap = 0;
    for (int i = 0; i < 3; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_streak[i] = 0;
    end
  endtask

  task automatic model_edge(input bit l, input bit r, input bit h);
    bit dl, dr, tk, both, own;
    int want, cinc;
    bit rawv[3];
    k++;
    tk = rose_at(k - 1);
    dl = m_deb[0]; dr = m_deb[1];
    cinc = (tk && m_cnt < 31) ? m_cnt + 1 : m_cnt;
    both = dl && dr;
    want = (dl && !dr) ? 1 : ((dr && !dl) ? 2 : 0);
    if (m_side == 0) begin
      if (want != 0) begin m_side = want; m_tap = 0; m_cnt = 0; end
      else m_cnt = cinc;
    end else if (!m_tap) begin
      own = (m_side == 1) ? dl : dr;
      if (both) begin m_side = 0; m_cnt = 0; end
      else if (!own) begin
        if (cinc < TT) begin m_tap = 1; m_cnt = cinc; end
        else begin m_side = 0; m_cnt = 0; end
      end else m_cnt = cinc;
    end else begin
      if (both) begin m_side = 0; m_tap = 0; m_cnt = 0; end
      else if (want != 0) begin m_side = want; m_tap = 0; m_cnt = 0; end
      else if (cinc >= TF) begin m_side = 0; m_tap = 0; m_cnt = 0; end
      else m_cnt = cinc;
    end
    if (m_deb[2] && !m_hprev) m_haz = !m_haz;
    m_hprev = m_deb[2];
    // A level is accepted after DEB consecutive edges of disagreement.
    for (int i = 0; i < 3; i++) begin
      if (m_s2[i] != m_deb[i]) begin
        m_streak[i]++;
        if (m_streak[i] == DEB) begin m_deb[i] = m_s2[i]; m_streak[i] = 0; end
      end else m_streak[i] = 0;
    end
    rawv[0] = l; rawv[1] = r; rawv[2] = h;
    for (int i = 0; i < 3; i++) begin m_s2[i] = m_s1[i]; m_s1[i] = rawv[i]; end
  endtask

  task automatic step(input bit rst, input bit l, input bit r, input bit h);
    RST = rst; SW_LEFT = l; SW_RIGHT = r; BTN_HAZ = h;
    cur_l = l; cur_r = r; cur_h = h;
    if (rst) model_reset();
    else model_edge(l, r, h);
    expq.push_back({div_level(k), m_side == 1, m_side == 2, m_haz});
    @(negedge Clk);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step(1'b0, cur_l, cur_r, cur_h);
  endtask

  always @(negedge Clk) begin
    logic [3:0] want, got;
    cyc++;
    if (expq.size() > 0) begin
      want = expq.pop_front();
      got  = {Clk_2Hz, LEFT, RIGHT, HAZ};
      checks++;
      if (got !== want)begin
        errors++;
        $display("FAIL outputs{Clk_2Hz,LEFT,RIGHT,HAZ} cycle %0d: got %b expected %b", cyc, got,
                 want);
      end
    end
  end

  initial begin
    cur_l = 0; cur_r = 0; cur_h = 0;
    model_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    hold(25);
    // Bouncy left stalk, then held past several ticks, then released
    step(1'b0, 1, 0, 0); step(1'b0, 0, 0, 0); step(1'b0, 1, 0, 0); step(1'b0, 0, 0, 0);
    step(1'b0, 1, 0, 0); hold(50);
    step(1'b0, 0, 0, 0); hold(20);
    // Right tap then expiry
    step(1'b0, 0, 1, 0); hold(7);
    step(1'b0, 0, 0, 0); hold(150);
    // Fault during RIGHT_ON
    step(1'b0, 0, 1, 0); hold(20);
    step(1'b0, 1, 1, 0); hold(15);
    step(1'b0, 0, 0, 0); hold(20);
    // Left stalk overriding a right tap
    step(1'b0, 0, 1, 0); hold(7);
    step(1'b0, 0, 0, 0); hold(30);
    step(1'b0, 1, 0, 0); hold(7);
    step(1'b0, 0, 0, 0); hold(40);
    // Hazard presses with left stalk held
    step(1'b0, 1, 0, 0); hold(15);
    step(1'b0, 1, 0, 1); hold(10);
    step(1'b0, 1, 0, 0); hold(12);
    step(1'b0, 1, 0, 1); hold(10);
    step(1'b0, 1, 0, 0); hold(12);
    step(1'b0, 0, 0, 0); hold(20);
    // Reset pulse in the middle of a tap
    step(1'b0, 0, 1, 0); hold(7);
    step(1'b0, 0, 0, 0); hold(30);
    step(1'b1, 0, 0, 0);
    hold(20);
    // Random activity with bounce and rare resets
    for (int n = 0; n < 4000; n++) begin
      bit l, r, h, rs;
      l  = ($urandom_range(0, 17) == 0) ? !cur_l : cur_l;
      r  = ($urandom_range(0, 23) == 0) ? !cur_r : cur_r;
      h  = ($urandom_range(0, 29) == 0) ? !cur_h : cur_h;
      rs = ($urandom_range(0, 799) == 0);
      step(rs, l, r, h);
    end
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/turn_signal_ctrl.md
# turn_signal_ctrl

Driver-input front end for the Thunderbird tail-light sequencer. Runs on the system clock and conditions the raw turn-stalk and hazard-button inputs. It generates the LEFT, RIGHT and HAZ levels and the Clk_2Hz sequencing clock that the tail-light sequencer consumes. It adds debounce, a hazard push-on/push-off latch, a lane-change "tap" mode and fault suppression for both stalk contacts closed at once.

## Interface

Parameters:
- DEB_CYCLES, 500000: consecutive stable Clk cycles needed to accept a new input level (10 ms at 50 MHz).
- HALF_DIV, 12500000: Clk cycles per Clk_2Hz half period (2 Hz at 50 MHz).
- TAP_TICKS, 2: a stalk released before this many Clk_2Hz rising edges counts as a tap.
- TAP_FLASHES, 12: total Clk_2Hz rising edges a tap keeps the signal on (3 full sequences).

Ports:
- Clk, input, 1: system clock. This is the only clock.
- RST, input, 1: reset, synchronous, active-high.
- SW_LEFT, input, 1: raw left stalk contact. Asynchronous, bouncy.
- SW_RIGHT, input, 1: raw right stalk contact. Asynchronous, bouncy.
- BTN_HAZ, input, 1: raw momentary hazard button. Asynchronous, bouncy.
- Clk_2Hz, output, 1: divided sequencing clock, 50 % duty.
- LEFT, output, 1: left turn request.
- RIGHT, output, 1: right turn request.
- HAZ, output, 1: hazard request.

## Operation

- Synchronizer: each raw input passes through 2 flops.
- Debouncer, one per input:
  - Each input has a counter and a debounced flop. The counter clears whenever the synced value equals the debounced value.
  - While the two differ, the counter increments. When it reaches DEB_CYCLES-1, the debounced flop takes the synced value and the counter clears.
  - Debounced values reset to 0.
- Divider:
  - The counter runs 0..HALF_DIV-1. At the terminal count it wraps to 0 and Clk_2Hz toggles.
  - "tick" is a 1-cycle internal strobe, asserted in the cycle Clk_2Hz is registered 0→1.
- Hazard latch:
  - HAZ toggles on each debounced 0→1 edge of BTN_HAZ. Releasing the button has no effect.
  - HAZ is independent of the turn FSM. The sequencer already gives HAZ priority.
- Turn FSM. Inputs are the debounced L and R. edge_cnt is 5 bits, clears on every state entry and increments on tick, saturating at 31.
  - IDLE:
    - L & ~R → LEFT_ON.
    - R & ~L → RIGHT_ON.
  - LEFT_ON (LEFT=1):
    - L & R → IDLE (fault).
    - ~L with edge_cnt < TAP_TICKS → LEFT_TAP, keeping edge_cnt (no clear on this transition only).
    - ~L with edge_cnt ≥ TAP_TICKS → IDLE.
  - LEFT_TAP (LEFT=1):
    - R & ~L → RIGHT_ON.
    - L & ~R → LEFT_ON.
    - L & R → IDLE.
    - edge_cnt reaches TAP_FLASHES → IDLE.
  - RIGHT_ON and RIGHT_TAP mirror LEFT_ON and LEFT_TAP.
- Outputs: LEFT and RIGHT are registered decodes of the state. They are never both 1.
- Reset mid-operation: asserting RST for one cycle forces the reset state on the next edge, regardless of state, counters or inputs.

## Timing

- Reset values:
  - Clk_2Hz=0, LEFT=0, RIGHT=0, HAZ=0.
  - FSM=IDLE.
  - All counters 0.
  - Synchronizer and debounced flops 0.
- Input latency: a clean raw level change reaches the debounced flop exactly DEB_CYCLES+2 Clk edges later. LEFT, RIGHT and HAZ respond one edge after that, i.e. DEB_CYCLES+3.
- Bounce rejection: any synced glitch shorter than DEB_CYCLES cycles produces no output change.
- Clk_2Hz:
  - First rising edge at Clk edge HALF_DIV after reset release.
  - Period 2·HALF_DIV cycles.
  - The divider runs free. It is unaffected by the FSM and HAZ.
- Tap expiry: LEFT or RIGHT falls in the cycle after the tick that brings edge_cnt to TAP_FLASHES.
- Simultaneous events:
  - A tick in the same cycle as a stalk release is counted before the tap/hold decision.
  - A fault takes precedence over a tap expiry.

## Test plan

All scenarios use DEB_CYCLES=4, HALF_DIV=5, TAP_TICKS=2 and TAP_FLASHES=12.

- Reset and divider:
  - Stimulus: hold RST 3 cycles, then release.
  - Required: all outputs 0; Clk_2Hz rises at edge 5 after release, then toggles every 5 cycles.
- Debounce:
  - Stimulus: SW_LEFT bounces 1,0,1,0 at 1-cycle spacing, then holds 1.
  - Required: LEFT=1 exactly 7 cycles after the final 0→1; no LEFT pulse during the bounce.
- Hold and release:
  - Stimulus: SW_LEFT held for 4 ticks, then released.
  - Required: IDLE, LEFT=0 at 7 cycles after release; RIGHT stays 0 throughout.
- Tap:
  - Stimulus: SW_RIGHT pulse ending before the 2nd tick.
  - Required: RIGHT stays 1 until 1 cycle after the 12th tick since RIGHT_ON entry, then 0.
- Fault and tap override:
  - Stimulus: both stalks closed during RIGHT_ON.
  - Required: RIGHT→0 with LEFT=0.
  - Stimulus: SW_LEFT asserted during RIGHT_TAP.
  - Required: LEFT=1 and RIGHT=0 on the same edge.
- Hazard:
  - Stimulus: two clean BTN_HAZ presses, with SW_LEFT held throughout.
  - Required: HAZ 0→1 on the first press, 1→0 on the second; LEFT unaffected.
  - Stimulus: RST pulse mid-tap.
  - Required: all outputs 0 on the next edge.
